// File: rtl/sfifo_fwft.sv
// Single-clock FWFT FIFO with a registered head entry, occupancy count and almost flags.
// Define SFIFO_PEAK_EN to add the peak port: the high-water mark of count since the last rst or flush.
module sfifo_fwft #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty
`ifdef SFIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] peak
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;

  logic w_push;
  logic w_pop;
  logic w_mem_empty;
  logic w_load_in;
  logic w_load_mem;
  logic w_mem_wr;

  assign in_ready     = (r_count < DEPTH_C);
  assign out_valid    = (r_count != '0);
  assign out_data     = r_head;
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);

  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  // Memory holds everything behind the head; full/empty differ only in the pointer MSB.
  assign w_mem_empty = (r_wptr == r_rptr);
  assign w_load_mem  = w_pop & ~w_mem_empty;
  // A push goes straight to the head when the head is (or is about to be) vacant.
  assign w_load_in   = w_push & w_mem_empty & (~out_valid | w_pop);
  assign w_mem_wr    = w_push & ~w_load_in;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_mem_wr)
        r_wptr <= r_wptr + PW'(1);
      if (w_load_mem)
        r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_head <= '0;
    else if (!flush) begin
      if (w_load_in)
        r_head <= in_data;
      else if (w_load_mem)
        r_head <= r_mem[r_rptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_wr)
      r_mem[r_wptr[AW-1:0]] <= in_data;
  end

`ifdef SFIFO_PEAK_EN
  logic [CW-1:0] r_peak;

  always_ff @(posedge clk) begin
    if (rst || flush)
      r_peak <= '0;
    else if (r_count > r_peak)
      r_peak <= r_count;
  end

  assign peak = r_peak;
`endif

endmodule
